cond_logic_mc: RTL and testbench
================================

// Module: cond_logic_mc
// PURPOSE
//  Conditional-execution stage directly downstream of the multicycle main FSM and instruction decoder.
//  Holds the NZCV flag register and evaluates the 4-bit ARM condition field against the stored flags.
//  Gates the FSM/decoder write requests (RegW, MemW, PCS) into architectural write enables (RegWrite, MemWrite, PCWrite).
//  Uses a registered condition result (CondExDelayed), so a squashed instruction cannot corrupt state in later FSM cycles.
// PARAMETERS
//  FLAG_RESET  4'b0000  NZCV value loaded on reset, order {N,Z,C,V}
//  CNT_W       32       width of statistics counters (used only with CONDLOGIC_STATS_EN)
// PORTS
//  clk            in   1      rising-edge clock, the only clock
//  reset          in   1      synchronous, active-high
//  Cond           in   4      Instr[31:28] condition field
//  ALUFlags       in   4      {N,Z,C,V} from ALU, current cycle
//  FlagW          in   2      [1]: write N,Z   [0]: write C,V   (from decoder)
//  PCS            in   1      instruction writes PC (branch or Rd==15)
//  NextPC         in   1      FSM unconditional PC update (fetch)
//  RegW           in   1      FSM register-write request
//  MemW           in   1      FSM memory-write request
//  Decode         in   1      high while FSM is in DECODE (stats only)
//  StatClr        in   1      clear statistics counters (stats only)
//  PCWrite        out  1      PC enable
//  RegWrite       out  1      register-file write enable
//  MemWrite       out  1      data-memory write enable
//  Flags          out  4      current NZCV register (debug visibility)
//  ExecCnt        out  CNT_W  executed-instruction count (stats only)
//  SquashCnt      out  CNT_W  squashed-instruction count (stats only)
// BEHAVIOUR
//  CondEx is combinational from Cond and the Flags register, not from ALUFlags:
//   0000 EQ Z, 0001 NE ~Z, 0010 CS C, 0011 CC ~C, 0100 MI N, 0101 PL ~N, 0110 VS V, 0111 VC ~V,
//   1000 HI C&~Z, 1001 LS ~C|Z, 1010 GE N==V, 1011 LT N!=V, 1100 GT ~Z&(N==V),
//   1101 LE Z|(N!=V), 1110 AL 1, 1111 -> 0 (never executes).
//  FlagWrite = FlagW & {2{CondEx}}.
//  On the clock edge: Flags[3:2] <= ALUFlags[3:2] if FlagWrite[1]; Flags[1:0] <= ALUFlags[1:0] if FlagWrite[0].
//  CondExDelayed <= CondEx on every clock edge (1-cycle latency). It is the value computed in the previous FSM state.
//  Outputs are combinational from inputs and registers, with no added latency:
//   RegWrite = RegW & CondExDelayed; MemWrite = MemW & CondExDelayed;
//   PCWrite = NextPC | (PCS & CondExDelayed).
//  Flags written in EXECUTE become visible to CondEx in ALUWB. CondExDelayed in ALUWB still holds the EXECUTE-cycle (old-flag) result.
//  A single FlagW bit updates only its own flag pair; the other pair holds.
//  Reset: Flags=FLAG_RESET, CondExDelayed=0. Hence RegWrite=MemWrite=0 and PCWrite=NextPC in the first cycle after reset.
//  Reset asserted mid-instruction aborts the instruction: a pending write enable drops in the same cycle reset is sampled high.
//  X on Cond or Flags is not masked. The bench must drive Cond every cycle after reset.
// CONFIGURATION
//  CONDLOGIC_STATS_EN defined:
//   Decode, StatClr, ExecCnt and SquashCnt exist.
//   On each edge with Decode=1: ExecCnt+1 if CondEx, else SquashCnt+1.
//   Counters saturate at all-ones; no wrap.
//   StatClr or reset -> both counters 0. StatClr takes priority over an increment in the same cycle.
//  CONDLOGIC_STATS_EN undefined: those four ports and the counters are absent. Core behaviour is identical.
// TESTING
//  T1 reset: reset=1 for 2 cycles, NextPC=1 -> Flags=FLAG_RESET, RegWrite=0, MemWrite=0, PCWrite=1.
//  T2 EQ squash:
//     Flags=0000, Cond=0000, RegW=1 for 2 cycles -> RegWrite=0 in both cycles.
//     Repeat with Flags=0100 -> RegWrite=1 in the 2nd cycle only.
//  T3 partial flag write:
//     Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111 -> Flags=1100 next cycle.
//     Then FlagW=01 -> Flags=1111.
//  T4 delayed condition: cycle0 Cond=0001 (NE), Flags=0000, FlagW=11, ALUFlags=0100.
//     Cycle1: Flags=0100 and CondExDelayed=1, so RegW=1 -> RegWrite=1.
//     Cycle2: CondExDelayed=0 -> RegWrite=0.
//  T5 branch: Cond=1010 (GE), Flags=1000, PCS=1, NextPC=0 -> PCWrite=0 next cycle.
//     Same with Flags=1001 -> PCWrite=1.
//     Cond=1111 under any flags -> PCWrite=0.
//  T6 stats (CONDLOGIC_STATS_EN, CNT_W=4):
//     20 Decode pulses with Cond=1110 -> ExecCnt=15 (saturated), SquashCnt=0.
//     Then StatClr=1 together with Decode=1 -> both 0.

Source files
------------

// File: rtl/cond_logic_mc_if.sv
// Signal bundle between the multicycle FSM/decoder and the conditional-execution stage.
// Stats signals exist only when CONDLOGIC_STATS_EN is defined.
interface cond_logic_mc_if
`ifdef CONDLOGIC_STATS_EN
    #(parameter int CNT_W = 32)
`endif
    ();
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;
`ifdef CONDLOGIC_STATS_EN
    logic             Decode;
    logic             StatClr;
    logic [CNT_W-1:0] ExecCnt;
    logic [CNT_W-1:0] SquashCnt;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, Decode, StatClr,
        input  PCWrite, RegWrite, MemWrite, Flags, ExecCnt, SquashCnt
    );
    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, Decode, StatClr,
        output PCWrite, RegWrite, MemWrite, Flags, ExecCnt, SquashCnt
    );
`else
    modport master (
        output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        input  PCWrite, RegWrite, MemWrite, Flags
    );
    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
        output PCWrite, RegWrite, MemWrite, Flags
    );
`endif
endinterface

// File: rtl/cond_logic_mc.sv
// Conditional-execution stage: NZCV register, condition evaluation and write-enable gating.
// Optional execute/squash statistics counters are enabled by defining CONDLOGIC_STATS_EN.
module cond_logic_mc #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
`ifdef CONDLOGIC_STATS_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic           clk,
    input  logic           reset,
    cond_logic_mc_if.slave bus
);
    logic [3:0] r_flags;
    logic       r_cond_ex_d;
    logic       w_cond_ex;
    logic [1:0] w_flag_write;
    logic       w_cond_gate;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Condition is evaluated against the stored flags, never the live ALU flags.
    always_comb begin
        w_cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_flag_write = bus.FlagW & {2{w_cond_ex}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags     <= FLAG_RESET;
            r_cond_ex_d <= 1'b0;
        end else begin
            if (w_flag_write[1]) r_flags[3:2] <= bus.ALUFlags[3:2];
            if (w_flag_write[0]) r_flags[1:0] <= bus.ALUFlags[1:0];
            r_cond_ex_d <= w_cond_ex;
        end
    end

    // Reset kills conditional writes in the very cycle it is sampled; fetch PC update is unaffected.
    assign w_cond_gate  = r_cond_ex_d & ~reset;
    assign bus.RegWrite = bus.RegW & w_cond_gate;
    assign bus.MemWrite = bus.MemW & w_cond_gate;
    assign bus.PCWrite  = bus.NextPC | (bus.PCS & w_cond_gate);
    assign bus.Flags    = r_flags;

`ifdef CONDLOGIC_STATS_EN
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    // Counters saturate at all-ones; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || bus.StatClr) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
        end else if (bus.Decode) begin
            if (w_cond_ex) begin
                if (r_exec_cnt != '1) r_exec_cnt <= r_exec_cnt + ONE;
            end else begin
                if (r_squash_cnt != '1) r_squash_cnt <= r_squash_cnt + ONE;
            end
        end
    end

    assign bus.ExecCnt   = r_exec_cnt;
    assign bus.SquashCnt = r_squash_cnt;
`endif
endmodule

// File: tb/tb_cond_logic_mc.sv
// Directed bench for cond_logic_mc: condition-code table plus multi-cycle sequences.
// Stats sequence is compiled only when CONDLOGIC_STATS_EN is defined.
module tb_cond_logic_mc;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

`ifdef CONDLOGIC_STATS_EN
    cond_logic_mc_if #(.CNT_W(4)) bus ();
    cond_logic_mc #(.FLAG_RESET(4'b0000), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    cond_logic_mc_if bus ();
    cond_logic_mc #(.FLAG_RESET(4'b0000)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] flags;
        logic       pcs;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       e_rw;
        logic       e_mw;
        logic       e_pw;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cond, input logic [1:0] flagw, input logic [3:0] alu,
                         input logic pcs, input logic nextpc, input logic regw, input logic memw);
        bus.Cond     = cond;
        bus.FlagW    = flagw;
        bus.ALUFlags = alu;
        bus.PCS      = pcs;
        bus.NextPC   = nextpc;
        bus.RegW     = regw;
        bus.MemW     = memw;
    endtask

    // Loads the flag register through an AL instruction; leaves the delayed condition at 1.
    task automatic set_flags(input logic [3:0] v);
        drive(4'b1110, 2'b11, v, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.FlagW = 2'b00;
    endtask

    task automatic check_outs(input string tag, input logic rw, input logic mw, input logic pw);
        chk({tag, ".RegWrite"}, {31'b0, bus.RegWrite}, {31'b0, rw});
        chk({tag, ".MemWrite"}, {31'b0, bus.MemWrite}, {31'b0, mw});
        chk({tag, ".PCWrite"},  {31'b0, bus.PCWrite},  {31'b0, pw});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0]  = '{4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'b0011, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0100, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{4'b0101, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0110, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'b0111, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b1000, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'b1000, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'b1001, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'b1001, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'b1010, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{4'b1010, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{4'b1011, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{4'b1100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{4'b1100, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{4'b1101, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{4'b1101, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{4'b1110, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[21] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[23] = '{4'b1011, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[24] = '{4'b1100, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);
`ifdef CONDLOGIC_STATS_EN
        bus.Decode  = 1'b0;
        bus.StatClr = 1'b0;
`endif

        // T1: two reset cycles with a fetch request pending
        tick();
        tick();
        @(negedge clk);
        chk("t1.flags", {28'b0, bus.Flags}, 32'h0);
        check_outs("t1.rst", 1'b0, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_outs("t1.post", 1'b0, 1'b0, 1'b1);
        tick();

        // Condition-code table: flags loaded, condition evaluated, gated one cycle later
        for (int i = 0; i < 25; i++) begin
            set_flags(vecs[i].flags);
            drive(vecs[i].cond, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            drive(4'b1110, 2'b00, 4'b0000, vecs[i].pcs, vecs[i].nextpc, vecs[i].regw, vecs[i].memw);
            @(negedge clk);
            chk($sformatf("vec%0d.flags", i), {28'b0, bus.Flags}, {28'b0, vecs[i].flags});
            check_outs($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_mw, vecs[i].e_pw);
            tick();
        end

        // T2: EQ held for two cycles, first with Z clear then with Z set
        set_flags(4'b0000);
        drive(4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); chk("t2a.c1", {31'b0, bus.RegWrite}, 32'h0);
        tick();
        @(negedge clk); chk("t2a.c2", {31'b0, bus.RegWrite}, 32'h0);
        tick();
        set_flags(4'b0100);
        drive(4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); chk("t2b.c1", {31'b0, bus.RegWrite}, 32'h0);
        tick();
        @(negedge clk); chk("t2b.c2", {31'b0, bus.RegWrite}, 32'h1);
        tick();

        // T3: each FlagW bit updates only its own pair
        set_flags(4'b0000);
        drive(4'b1110, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk); chk("t3.nz", {28'b0, bus.Flags}, 32'hC);
        drive(4'b1110, 2'b01, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk); chk("t3.cv", {28'b0, bus.Flags}, 32'hF);

        // T4: NE evaluated on old flags while it sets Z
        set_flags(4'b0000);
        drive(4'b0001, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0001, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4.flags", {28'b0, bus.Flags}, 32'h4);
        chk("t4.c1", {31'b0, bus.RegWrite}, 32'h1);
        tick();
        @(negedge clk); chk("t4.c2", {31'b0, bus.RegWrite}, 32'h0);
        tick();

        // Reset mid-instruction drops pending conditional writes in the same cycle
        set_flags(4'b1010);
        drive(4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk); check_outs("rmid.pre", 1'b1, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        @(negedge clk); check_outs("rmid.rst", 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk); chk("rmid.flags", {28'b0, bus.Flags}, 32'h0);
        reset = 1'b0;
        tick();

`ifdef CONDLOGIC_STATS_EN
        // T6: saturating execute counter, squash counter, clear beats increment
        drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6.exec0", {28'b0, bus.ExecCnt}, 32'h0);
        chk("t6.sq0", {28'b0, bus.SquashCnt}, 32'h0);
        bus.Decode = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        bus.Decode = 1'b0;
        @(negedge clk);
        chk("t6.exec_sat", {28'b0, bus.ExecCnt}, 32'hF);
        chk("t6.sq_after_exec", {28'b0, bus.SquashCnt}, 32'h0);
        bus.Cond   = 4'b1111;
        bus.Decode = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.Decode = 1'b0;
        @(negedge clk);
        chk("t6.sq3", {28'b0, bus.SquashCnt}, 32'h3);
        chk("t6.exec_hold", {28'b0, bus.ExecCnt}, 32'hF);
        bus.Cond    = 4'b1110;
        bus.Decode  = 1'b1;
        bus.StatClr = 1'b1;
        tick();
        bus.Decode  = 1'b0;
        bus.StatClr = 1'b0;
        @(negedge clk);
        chk("t6.exec_clr", {28'b0, bus.ExecCnt}, 32'h0);
        chk("t6.sq_clr", {28'b0, bus.SquashCnt}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
